// File: rtl/bch_encoder_serial.sv
// Systematic serial BCH(31,16) encoder, t=3, LFSR division by g(x); MSB-first bit stream.
// Optional macro BCH_ENC_PAR_OUT_EN adds a parallel capture of each completed codeword.
module bch_encoder_serial #(
    parameter int N = 31,
    parameter int K = 16,
    parameter logic [N-K:0] GEN = 16'h8FAF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         msg_valid,
    output logic         msg_ready,
    input  logic [K-1:0] msg_data,
    output logic         cw_valid,
    input  logic         cw_ready,
    output logic         cw_bit,
    output logic         cw_first,
    output logic         cw_last,
    output logic         busy
`ifdef BCH_ENC_PAR_OUT_EN
    ,
    output logic [N-1:0] cw_word,
    output logic         cw_word_valid
`endif
);

    localparam int PAR_W = N - K;
    localparam logic [4:0] LAST_DATA = 5'(K - 1);
    localparam logic [4:0] LAST_BEAT = 5'(N - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

    state_t             state, state_nxt;
    logic [K-1:0]       msg_sr;
    logic [PAR_W-1:0]   par;
    logic [4:0]         beat_cnt;
    logic               beat;

    // One step of polynomial division: feedback is the incoming bit plus the remainder MSB.
    function automatic logic [PAR_W-1:0] lfsr_step(input logic [PAR_W-1:0] p, input logic din);
        logic fb;
        fb = din ^ p[PAR_W-1];
        return {p[PAR_W-2:0], 1'b0} ^ (fb ? GEN[PAR_W-1:0] : '0);
    endfunction

    assign beat = cw_valid && cw_ready;

    always_comb begin
        state_nxt = state;
        msg_ready = 1'b0;
        cw_valid  = 1'b0;
        cw_bit    = 1'b0;
        cw_first  = 1'b0;
        cw_last   = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                msg_ready = 1'b1;
                if (msg_valid) state_nxt = DATA;
            end
            DATA: begin
                cw_valid = 1'b1;
                busy     = 1'b1;
                cw_bit   = msg_sr[K-1];
                cw_first = (beat_cnt == 5'd0);
                if (cw_ready && beat_cnt == LAST_DATA) state_nxt = PARITY;
            end
            PARITY: begin
                cw_valid = 1'b1;
                busy     = 1'b1;
                cw_bit   = par[PAR_W-1];
                cw_last  = (beat_cnt == LAST_BEAT);
                if (cw_ready && beat_cnt == LAST_BEAT) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            msg_sr   <= '0;
            par      <= '0;
            beat_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (msg_valid) begin
                        msg_sr   <= msg_data;
                        par      <= '0;
                        beat_cnt <= '0;
                    end
                end
                DATA: begin
                    if (cw_ready) begin
                        par      <= lfsr_step(par, msg_sr[K-1]);
                        msg_sr   <= {msg_sr[K-2:0], 1'b0};
                        beat_cnt <= beat_cnt + 5'd1;
                    end
                end
                PARITY: begin
                    if (cw_ready) begin
                        par      <= {par[PAR_W-2:0], 1'b0};
                        beat_cnt <= (beat_cnt == LAST_BEAT) ? 5'd0 : beat_cnt + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BCH_ENC_PAR_OUT_EN
    // Shift register gathers beats; cw_word only updates when a codeword completes.
    logic [N-2:0] cap_sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_sr        <= '0;
            cw_word       <= '0;
            cw_word_valid <= 1'b0;
        end else begin
            cw_word_valid <= beat && cw_last;
            if (beat) begin
                cap_sr <= {cap_sr[N-3:0], cw_bit};
                if (cw_last) cw_word <= {cap_sr, cw_bit};
            end
        end
    end
`endif

endmodule

// File: tb/tb_bch_encoder_serial.sv
// Directed bench for bch_encoder_serial: hand-computed parity table, stalls and mid-word reset.
module tb_bch_encoder_serial;

    logic        clk = 1'b0;
    logic        reset;
    logic        msg_valid;
    logic        msg_ready;
    logic [15:0] msg_data;
    logic        cw_valid;
    logic        cw_ready;
    logic        cw_bit;
    logic        cw_first;
    logic        cw_last;
    logic        busy;
`ifdef BCH_ENC_PAR_OUT_EN
    logic [30:0] cw_word;
    logic        cw_word_valid;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    bch_encoder_serial dut (
        .clk       (clk),
        .reset     (reset),
        .msg_valid (msg_valid),
        .msg_ready (msg_ready),
        .msg_data  (msg_data),
        .cw_valid  (cw_valid),
        .cw_ready  (cw_ready),
        .cw_bit    (cw_bit),
        .cw_first  (cw_first),
        .cw_last   (cw_last),
        .busy      (busy)
`ifdef BCH_ENC_PAR_OUT_EN
        ,
        .cw_word       (cw_word),
        .cw_word_valid (cw_word_valid)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accept one message, drain its 31 beats (optionally with random stalls), compare the stream.
    task automatic send_word(input logic [15:0] msg, input logic [14:0] parity, input bit stall);
        logic [30:0] cw;
        logic [30:0] exp_cw;
        int          beats;
        int          cycles;
        logic        held_bit, held_first, held_last;
        bit          was_stall;
        cw        = '0;
        exp_cw    = {msg, parity};
        beats     = 0;
        cycles    = 0;
        was_stall = 1'b0;
        held_bit  = 1'b0;
        held_first = 1'b0;
        held_last  = 1'b0;
        chk("ready_before_accept", 32'(msg_ready), 32'd1);
        msg_valid = 1'b1;
        msg_data  = msg;
        cw_ready  = 1'b1;
        @(negedge clk);
        msg_valid = 1'b0;
        msg_data  = 16'($urandom);
        while (beats < 31 && cycles < 400) begin
            chk("cw_valid_in_word", 32'(cw_valid), 32'd1);
            chk("busy_in_word", 32'(busy), 32'd1);
            chk("msg_ready_in_word", 32'(msg_ready), 32'd0);
            if (was_stall) begin
                chk("stall_hold_bit", 32'(cw_bit), 32'(held_bit));
                chk("stall_hold_first", 32'(cw_first), 32'(held_first));
                chk("stall_hold_last", 32'(cw_last), 32'(held_last));
            end
            chk("cw_first_flag", 32'(cw_first), 32'(beats == 0));
            chk("cw_last_flag", 32'(cw_last), 32'(beats == 30));
            cw_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cw_ready) begin
                cw        = {cw[29:0], cw_bit};
                beats++;
                was_stall = 1'b0;
            end else begin
                was_stall  = 1'b1;
                held_bit   = cw_bit;
                held_first = cw_first;
                held_last  = cw_last;
            end
            cycles++;
            @(negedge clk);
        end
        cw_ready = 1'b1;
        chk("beats_done", 32'(beats), 32'd31);
        if (!stall) chk("cycles_per_word", 32'(cycles), 32'd31);
        chk("codeword", 32'(cw), 32'(exp_cw));
        chk("idle_msg_ready", 32'(msg_ready), 32'd1);
        chk("idle_cw_valid", 32'(cw_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
`ifdef BCH_ENC_PAR_OUT_EN
        chk("cw_word_valid_pulse", 32'(cw_word_valid), 32'd1);
        chk("cw_word", 32'(cw_word), 32'(exp_cw));
        @(negedge clk);
        chk("cw_word_valid_drop", 32'(cw_word_valid), 32'd0);
        chk("cw_word_hold", 32'(cw_word), 32'(exp_cw));
`endif
    endtask

    initial begin
        reset     = 1'b1;
        msg_valid = 1'b0;
        msg_data  = '0;
        cw_ready  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_msg_ready", 32'(msg_ready), 32'd1);
        chk("rst_cw_valid", 32'(cw_valid), 32'd0);
        chk("rst_cw_bit", 32'(cw_bit), 32'd0);
        chk("rst_cw_first", 32'(cw_first), 32'd0);
        chk("rst_cw_last", 32'(cw_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
`ifdef BCH_ENC_PAR_OUT_EN
        chk("rst_cw_word", 32'(cw_word), 32'd0);
        chk("rst_cw_word_valid", 32'(cw_word_valid), 32'd0);
`endif
        reset = 1'b0;

        // Idle with junk on msg_data and cw_ready: nothing may start.
        for (int i = 0; i < 8; i++) begin
            msg_data = 16'($urandom);
            cw_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("idle_ready", 32'(msg_ready), 32'd1);
            chk("idle_valid", 32'(cw_valid), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end

        send_word(16'h0001, 15'h0FAF, 1'b0);
        send_word(16'h0002, 15'h1F5E, 1'b0);
        send_word(16'h0003, 15'h10F1, 1'b0);
        send_word(16'h0000, 15'h0000, 1'b0);
        send_word(16'h0001, 15'h0FAF, 1'b1);

        // Abandon a word at beat 20 with reset, then encode cleanly again.
        msg_valid = 1'b1;
        msg_data  = 16'h0002;
        cw_ready  = 1'b1;
        @(negedge clk);
        msg_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_word_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("post_rst_cw_valid", 32'(cw_valid), 32'd0);
        chk("post_rst_msg_ready", 32'(msg_ready), 32'd1);
        chk("post_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("post_rst_no_beats", 32'(cw_valid), 32'd0);
        send_word(16'h0002, 15'h1F5E, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/bch_encoder_serial.md
Name: bch_encoder_serial

Overview:
- Systematic BCH(31,16) encoder over GF(2^5), t=3, primitive polynomial x^5+x^2+1.
- It is the transmit-side counterpart of the Berlekamp-Massey decoding chain.
- Accepts one 16-bit message per handshake and emits a 31-bit codeword serially, MSB first: 16 message bits, then 15 parity bits.
- Parity is computed by a 15-bit LFSR division by g(x). The output stream feeds the channel/error-injection path ahead of the syndrome block.

Parameters:
- N, 31, codeword length.
- K, 16, message length; parity length is N-K = 15.
- GEN, 16'h8FAF, generator polynomial g(x) = x^15+x^11+x^10+x^9+x^8+x^7+x^5+x^3+x^2+x+1. Bit i is the coefficient of x^i; bit 15 must be 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- msg_valid  in  1  message present on msg_data.
- msg_ready  out  1  encoder can accept a message.
- msg_data  in  K  message; bit K-1 is the highest-order coefficient, c30.
- cw_valid  out  1  cw_bit is valid.
- cw_ready  in  1  downstream accepts cw_bit.
- cw_bit  out  1  current codeword bit.
- cw_first  out  1  qualifies the beat carrying c30.
- cw_last  out  1  qualifies the beat carrying c0.
- busy  out  1  high in DATA or PARITY.

Behaviour:
- State machine: IDLE, DATA, PARITY. Registers:
  - msg_sr[K-1:0]: message shift register.
  - par[N-K-1:0]: LFSR.
  - beat_cnt[4:0]: counts accepted beats 0..30.
- Reset (clk edge with reset=1):
  - state=IDLE, msg_sr=0, par=0, beat_cnt=0.
  - Outputs: msg_ready=1, cw_valid=0, cw_bit=0, cw_first=0, cw_last=0, busy=0.
  - Reset mid-codeword abandons the word. No partial beats follow; msg_ready=1 on the first cycle after reset deasserts.
- IDLE:
  - msg_ready=1, cw_valid=0.
  - On msg_valid&&msg_ready: msg_sr<=msg_data, par<=0, beat_cnt<=0, go to DATA.
  - msg_data is ignored when msg_valid=0.
- DATA:
  - msg_ready=0, cw_valid=1, cw_bit=msg_sr[K-1].
  - cw_first=1 only when beat_cnt==0.
  - Beat fires on cw_valid&&cw_ready. On each beat:
    - fb = msg_sr[K-1] ^ par[N-K-1].
    - par <= {par[N-K-2:0],1'b0} ^ (fb ? GEN[N-K-1:0] : 0).
    - msg_sr <= msg_sr<<1, beat_cnt++.
  - The beat with beat_cnt==K-1 moves the state to PARITY.
- PARITY:
  - cw_valid=1, cw_bit=par[N-K-1].
  - On each beat: par <= par<<1 (zero fill), beat_cnt++.
  - cw_last=1 when beat_cnt==N-1. That beat moves the state to IDLE with beat_cnt<=0.
- Backpressure:
  - While cw_ready=0, cw_bit, cw_first, cw_last and all internal state hold.
  - cw_valid never drops mid-codeword.
- Latency and throughput:
  - First bit is valid the cycle after message acceptance.
  - Minimum 32 cycles per codeword; there is no accept-while-draining.
- All outputs are combinational decodes of registered state only. There is no input-to-output combinational path except through the handshake qualification of the advance.
- An all-zero message gives an all-zero codeword. No special case is needed.

Optional Feature:
- Macro: BCH_ENC_PAR_OUT_EN.
- When defined, add the following outputs:
  - cw_word (N bits).
  - cw_word_valid (1 bit).
- cw_word is built by shifting each accepted beat's bit into the LSB of a capture register. In the cycle after the cw_last beat:
  - cw_word holds the complete codeword, with bit 30 equal to c30.
  - cw_word_valid pulses high for exactly 1 cycle.
- cw_word holds its value until the next codeword completes. It resets to 0.
- When undefined, these ports and the capture register are absent, and serial behaviour is identical.

Test Plan:
- Reset then idle, no msg_valid -> msg_ready=1, cw_valid=0, busy=0 indefinitely.
- msg_data=16'h0001, cw_ready=1 -> 31 bits: fifteen 0s, then 1, then parity 15'h0FAF MSB first (000111110101111). cw_first on beat 0, cw_last on beat 30, msg_ready high again 32 cycles after acceptance.
- msg_data=16'h0002 -> parity 15'h1F5E. msg_data=16'h0003 -> parity 15'h10F1 (linearity check). msg_data=16'h0000 -> 31 zero bits.
- msg_data=16'h0001 with cw_ready randomly deasserted (~50%) -> identical bit sequence to the no-stall case, with bits held stable during stalls.
- Reset asserted at beat 20 -> next cycle IDLE with cw_valid=0. The next message 16'h0002 encodes correctly to parity 15'h1F5E.
- With BCH_ENC_PAR_OUT_EN: msg 16'h0001 -> cw_word=31'h00008FAF with a 1-cycle cw_word_valid pulse. msg 16'h0002 -> 31'h00011F5E.
